// File: rtl/decoder_2to4_seq.sv
// Registered 2-to-4 decoder fed by a small code FIFO. Each queued index is
// replayed as a one-hot word held for HOLD cycles, followed by one idle cycle.
module decoder_2to4_seq #(
    parameter int HOLD  = 2,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Y,
    input  logic       valid,
    output logic       ready,
    output logic [3:0] D,
    output logic       D_valid,
    output logic       busy,
    output logic [7:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC  = (AW+1)'(DEPTH);
    localparam logic [3:0]  HOLD_LOAD = 4'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   occ_q;
    logic [AW:0]   occ_d;
    logic [3:0]    hold_q;
    logic [3:0]    d_q;
    logic          d_valid_q;
    logic [7:0]    count_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [1:0]    head;

    assign full  = (occ_q == FULL_OCC);
    assign empty = (occ_q == '0);
    assign ready = !full;
    assign push  = valid && !full;
    // IDLE and GAP both take the next code as soon as one is queued.
    assign pop   = (state_q != DRIVE) && !empty;
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: storage array carries no reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Y;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            hold_q    <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            count_q   <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                IDLE, GAP: begin
                    if (pop) begin
                        d_q       <= 4'b0001 << head;
                        d_valid_q <= 1'b1;
                        hold_q    <= HOLD_LOAD;
                        count_q   <= count_q + 1'b1;
                        state_q   <= DRIVE;
                    end else begin
                        d_q       <= '0;
                        d_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DRIVE: begin
                    if (hold_q == '0) begin
                        d_q       <= '0;
                        d_valid_q <= 1'b0;
                        state_q   <= GAP;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    d_q       <= '0;
                    d_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign D       = d_q;
    assign D_valid = d_valid_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Scoreboard bench for decoder_2to4_seq: a timeline model predicts when each
// accepted code starts driving; a monitor pops expectations on every D_valid rise.
module tb_decoder_2to4_seq;

    localparam int HOLD  = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] code;
        int         acc;
        int         start;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] Y = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [3:0] D;
    logic       D_valid;
    logic       busy;
    logic [7:0] count;

    logic       rst1_n = 1'b1;
    logic [1:0] y1 = '0;
    logic       v1 = 1'b0;
    logic       ready1;
    logic [3:0] d1;
    logic       dv1;
    logic       busy1;
    logic [7:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    int   cyc;
    ent_t log_q[$];
    ent_t sb_q[$];
    int   pruned_n;
    int   last_start;
    int   accepted;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    decoder_2to4_seq #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Y       (Y),
        .valid   (valid),
        .ready   (ready),
        .D       (D),
        .D_valid (D_valid),
        .busy    (busy),
        .count   (count)
    );

    decoder_2to4_seq #(.HOLD(1), .DEPTH(DEPTH)) dut1 (
        .clk     (clk),
        .rst_n   (rst1_n),
        .Y       (y1),
        .valid   (v1),
        .ready   (ready1),
        .D       (d1),
        .D_valid (dv1),
        .busy    (busy1),
        .count   (cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Model: an accepted code starts one edge after acceptance, but never
    // before the previous code has finished its HOLD cycles plus one gap.
    task automatic drive(input logic v, input logic [1:0] y);
        int   occ;
        logic exp_ready;
        ent_t e;
        occ = 0;
        foreach (log_q[i]) if (log_q[i].start > cyc) occ++;
        exp_ready = (occ < DEPTH);
        check("ready", ready, exp_ready);
        valid = v;
        Y     = y;
        if (v && exp_ready) begin
            e.code  = y;
            e.acc   = cyc + 1;
            e.start = (e.acc + 1 > last_start + HOLD + 1) ? e.acc + 1 : last_start + HOLD + 1;
            last_start = e.start;
            log_q.push_back(e);
            sb_q.push_back(e);
            accepted++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        log_q.delete();
        sb_q.delete();
        pruned_n   = 0;
        last_start = -100;
        accepted   = 0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        valid  = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_D", D, 4'b0000);
        check("rst_D_valid", D_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", count, 8'd0);
        model_clear();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (cyc <= last_start + HOLD && guard < 3000) begin
            drive(1'b0, 2'b00);
            guard++;
        end
        check("drain_timeout", guard < 3000, 1'b1);
        drive(1'b0, 2'b00);
        drive(1'b0, 2'b00);
    endtask

    // Monitor: checks busy/count against the timeline every cycle and pops
    // the scoreboard whenever the DUT starts presenting a new word.
    bit         pv;
    int         run;
    logic [3:0] cur_exp;
    ent_t       me;
    always @(negedge clk) begin
        if (!(rst_n && mon_en)) begin
            pv  = 1'b0;
            run = 0;
        end else begin
            int   exp_cnt;
            logic exp_busy;
            exp_busy = 1'b0;
            exp_cnt  = pruned_n;
            foreach (log_q[i]) begin
                if (log_q[i].acc <= cyc && cyc <= log_q[i].start + HOLD) exp_busy = 1'b1;
                if (log_q[i].start <= cyc) exp_cnt++;
            end
            check("busy", busy, exp_busy);
            check("count", count, exp_cnt[7:0]);
            check("D_valid_vs_D", D_valid, D != 4'b0000);
            if (D_valid && !pv) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", D_valid, 1'b0);
                    cur_exp = 4'b0000;
                end else begin
                    me = sb_q.pop_front();
                    cur_exp = 4'b0001 << me.code;
                    check("D_code", D, cur_exp);
                    check("D_start", cyc, me.start);
                end
                run = 1;
            end else if (D_valid && pv) begin
                check("D_held", D, cur_exp);
                run++;
            end else if (!D_valid && pv) begin
                check("hold_len", run, HOLD);
            end
            pv = D_valid;
            while (log_q.size() > 0 && log_q[0].start + HOLD < cyc) begin
                pruned_n++;
                void'(log_q.pop_front());
            end
        end
    end

    initial begin
        logic [3:0] exp1 [4];
        int guard;
        exp1 = '{4'b0010, 4'b0000, 4'b0100, 4'b0000};

        #1;
        do_reset();

        // Single code after reset
        drive(1'b1, 2'b10);
        drain();
        check("single_count", count, 8'd1);
        check("single_busy", busy, 1'b0);

        // All four codes back-to-back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] c;
            c = 2'(i);
            drive(1'b1, c);
        end
        drain();
        check("b2b_count", count, 8'd4);

        // Backpressure: valid held high for 8 edges
        do_reset();
        repeat (8) drive(1'b1, 2'b11);
        drain();
        check("bp_count", count, accepted[7:0]);

        // Reset in the middle of the first DRIVE period
        do_reset();
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b10);
        drive(1'b1, 2'b11);
        check("pre_reset_driving", D_valid, 1'b1);
        #2;
        do_reset();
        repeat (10) drive(1'b0, 2'b00);
        drive(1'b1, 2'b00);
        drain();
        check("post_reset_count", count, 8'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic       v;
            logic [1:0] y;
            v = ($urandom_range(0, 2) != 0);
            y = 2'($urandom_range(0, 3));
            drive(v, y);
        end
        drain();

        // count wraps after 257 codes
        do_reset();
        guard = 0;
        while (accepted < 257 && guard < 5000) begin
            logic [1:0] y;
            y = 2'($urandom_range(0, 3));
            drive(1'b1, y);
            guard++;
        end
        check("wrap_push_timeout", guard < 5000, 1'b1);
        valid = 1'b0;
        drain();
        check("count_wrap", count, 8'd1);
        check("sb_empty", sb_q.size(), 0);

        // HOLD=1 instance: push 01 then 10
        mon_en = 1'b0;
        rst1_n = 1'b0;
        #1;
        check("h1_rst_D", d1, 4'b0000);
        @(negedge clk);
        rst1_n = 1'b1;
        check("h1_ready", ready1, 1'b1);
        v1 = 1'b1;
        y1 = 2'b01;
        @(negedge clk);
        y1 = 2'b10;
        @(negedge clk);
        v1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("h1_D[%0d]", i), d1, exp1[i]);
            check($sformatf("h1_D_valid[%0d]", i), dv1, exp1[i] != 4'b0000);
            @(negedge clk);
        end
        check("h1_count", cnt1, 8'd2);
        check("h1_busy", busy1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_2to4_seq.md
# decoder_2to4_seq

Registered 2-to-4 decoder with input buffering: the return path for the codes produced by the 4-to-2 priority encoder. It accepts 2-bit index codes (Y plus valid) through a valid/ready handshake, queues them in a small FIFO, and replays each one as a one-hot 4-bit line held for a programmable number of cycles. It sits downstream of the encoder and drives per-line request/grant wires.

## Interface
- HOLD, 2, cycles each decoded one-hot word is driven; legal range 1..15
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Y  in  2  encoded index: 00→D[0], 01→D[1], 10→D[2], 11→D[3]
- valid  in  1  Y is valid this cycle
- ready  out  1  block can accept a code this cycle
- D  out  4  registered one-hot decoded output; 0 when idle or in gap
- D_valid  out  1  high exactly when D is non-zero
- busy  out  1  FIFO non-empty or FSM not IDLE
- count  out  8  total codes driven since reset; wraps modulo 256

## Operation
- One clock; reset is asynchronous and active-low. Assertion forces all state and outputs to reset values immediately, without waiting for a clock edge.
- Reset values:
  - D=0, D_valid=0, busy=0, count=0, FIFO empty, FSM=IDLE.
  - ready=1 once rst_n is high.
- Accept: a code is written at a rising edge where valid && ready.
  - If ready=0, Y/valid are ignored and nothing is written.
- ready = !full, combinational from the FIFO occupancy only.
  - When full, there is no same-cycle bypass: ready stays 0 even if a pop occurs on that edge.
- FIFO: DEPTH entries of 2 bits, read/write pointers wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
  - Simultaneous push and pop (when not full and not empty) leaves occupancy unchanged.
- FSM states:
  - IDLE:
    - D=0.
    - If FIFO non-empty at an edge: pop the head, load D=1<<head, hold counter=HOLD-1, count+=1, go to DRIVE.
  - DRIVE:
    - D held constant.
    - If hold counter==0 at an edge: D←0, go to GAP.
    - Otherwise decrement the hold counter.
  - GAP:
    - D=0 for exactly one cycle.
    - At the next edge: if FIFO non-empty, pop and enter DRIVE as from IDLE; otherwise go to IDLE.
- A code written while the FIFO is empty can be popped on the immediately following edge, not the same edge.
- D_valid = (state==DRIVE), registered alongside D.
- busy = (state!=IDLE) || !empty.
- count increments only on the pop/load edge and wraps 255→0.

## Timing
- Latency: a code accepted at edge k (FIFO empty, FSM IDLE) appears on D after edge k+1 and is held for HOLD cycles.
- Back-to-back queued codes: period HOLD+1 cycles (HOLD cycles driven, 1 cycle zero).
  - D never changes directly from one one-hot value to another.
- Throughput: one accept per cycle until full; sustained drain rate is 1 code per HOLD+1 cycles.
- Reset asserted mid-DRIVE: D drops to 0 asynchronously.
  - Queued entries are discarded.
  - After release, the first edge with valid=1 is accepted normally.
- All outputs except ready are registered. ready is combinational from registered occupancy only; there is no path from valid or Y to ready.

## Test plan
- Reset/single code (HOLD=2):
  - Stimulus: deassert rst_n, push Y=10 at edge 1.
  - Response: D=0100 and D_valid=1 after edges 2–3, D=0 after edge 4, busy=0 after edge 5, count=1.
- All four codes back-to-back:
  - Stimulus: push 00,01,10,11 on consecutive edges.
  - Response: D sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000; count=4.
- Full/backpressure (DEPTH=4):
  - Stimulus: hold valid=1 with Y=11 for 8 edges.
  - Response: ready drops to 0 once 4 entries are queued; codes offered while ready=0 are dropped; exactly the accepted number of 1000 pulses is emitted.
- Reset mid-operation:
  - Stimulus: queue 3 codes, assert rst_n low during the first DRIVE cycle.
  - Response: D=0, count=0, busy=0 immediately; after release no stale codes are emitted.
- count wrap:
  - Stimulus: push 257 codes.
  - Response: count=1 at the end.
- HOLD=1 variant:
  - Stimulus: push 01,10.
  - Response: D=0010,0000,0100,0000 on successive cycles.
